// File: rtl/counter_arbiter.sv
// counter_arbiter: round-robin front end for the parallel counter pair.
// Two requesters issue CLR/INC/DEC/LOAD operations over valid/ready. At most
// one operation is granted per clock and applied to the selected counter
// with modulo-LIMIT arithmetic. Wrap events are reported as one-cycle pulses.
module counter_arbiter #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req1_valid,
  input  logic             req1_sel,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  input  logic             req2_valid,
  input  logic             req2_sel,
  input  logic [1:0]       req2_op,
  input  logic [WIDTH-1:0] req2_data,
  output logic             req2_ready,
  output logic [WIDTH-1:0] counter1,
  output logic [WIDTH-1:0] counter2,
  output logic             wrap1,
  output logic             wrap2
);

  localparam logic [1:0] op_clr  = 2'b00;
  localparam logic [1:0] op_inc  = 2'b01;
  localparam logic [1:0] op_dec  = 2'b10;
  localparam logic [1:0] op_load = 2'b11;

  // Largest legal counter value, and the modulus widened by one bit so the
  // LOAD range check still works when LIMIT = 2**WIDTH.
  localparam logic [WIDTH-1:0] max_val   = WIDTH'(LIMIT - 1);
  localparam logic [WIDTH:0]   limit_ext = (WIDTH + 1)'(LIMIT);

  logic             prio_reg;
  logic             prio_next;
  logic             grant1;
  logic             grant2;
  logic             grant_any;
  logic             g_sel;
  logic [1:0]       g_op;
  logic [WIDTH-1:0] g_data;

  logic [1:0][WIDTH-1:0] cnt_out;
  logic [1:0]            wrap_out;

  // Round-robin grant: contention goes to the favoured requester; ready is
  // held low throughout reset so nothing is accepted in a reset cycle.
  always_comb begin
    grant1 = 1'b0;
    grant2 = 1'b0;
    if (!rst) begin
      if (req1_valid && req2_valid) begin
        grant1 = ~prio_reg;
        grant2 = prio_reg;
      end else begin
        grant1 = req1_valid;
        grant2 = req2_valid;
      end
    end
  end

  // Pointer moves away from whoever was just served; holds when idle.
  always_comb begin
    prio_next = prio_reg;
    if (grant1) begin
      prio_next = 1'b1;
    end else if (grant2) begin
      prio_next = 1'b0;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_reg <= 1'b0;
    end else begin
      prio_reg <= prio_next;
    end
  end

  assign req1_ready = grant1;
  assign req2_ready = grant2;
  assign grant_any  = grant1 | grant2;
  assign g_sel      = grant2 ? req2_sel  : req1_sel;
  assign g_op       = grant2 ? req2_op   : req1_op;
  assign g_data     = grant2 ? req2_data : req1_data;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gen_cnt
      logic [WIDTH-1:0] cnt_reg;
      logic [WIDTH-1:0] cnt_next;
      logic             wrap_reg;
      logic             wrap_next;
      logic             hit;

      assign hit = grant_any && (g_sel == 1'(gi));

      // Apply the granted operation when it targets this counter; the wrap
      // flag is recomputed every cycle so it only lasts one cycle.
      always_comb begin
        cnt_next  = cnt_reg;
        wrap_next = 1'b0;
        if (hit) begin
          case (g_op)
            op_clr: cnt_next = '0;
            op_inc: begin
              if (cnt_reg == max_val) begin
                cnt_next  = '0;
                wrap_next = 1'b1;
              end else begin
                cnt_next = cnt_reg + WIDTH'(1);
              end
            end
            op_dec: begin
              if (cnt_reg == '0) begin
                cnt_next  = max_val;
                wrap_next = 1'b1;
              end else begin
                cnt_next = cnt_reg - WIDTH'(1);
              end
            end
            op_load: cnt_next = ({1'b0, g_data} < limit_ext) ? g_data : max_val;
            default: cnt_next = cnt_reg;
          endcase
        end
      end

      // Counter value and wrap pulse registers.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg  <= '0;
          wrap_reg <= 1'b0;
        end else begin
          cnt_reg  <= cnt_next;
          wrap_reg <= wrap_next;
        end
      end

      assign cnt_out[gi]  = cnt_reg;
      assign wrap_out[gi] = wrap_reg;
    end
  endgenerate

  assign counter1 = cnt_out[0];
  assign counter2 = cnt_out[1];
  assign wrap1    = wrap_out[0];
  assign wrap2    = wrap_out[1];

endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: a directed vector table covering the reset,
// wrap, contention, load and shared-target scenarios, followed by random
// traffic compared against a plain arithmetic reference model.
module tb_counter_arbiter;

  localparam int WIDTH = 4;
  localparam int LIMIT = 8;
  localparam logic [1:0] CLR = 2'd0, INC = 2'd1, DEC = 2'd2, LD = 2'd3;

  logic             clk = 1'b0;
  logic             rst;
  logic             req1_valid, req1_sel, req1_ready;
  logic [1:0]       req1_op;
  logic [WIDTH-1:0] req1_data;
  logic             req2_valid, req2_sel, req2_ready;
  logic [1:0]       req2_op;
  logic [WIDTH-1:0] req2_data;
  logic [WIDTH-1:0] counter1, counter2;
  logic             wrap1, wrap2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  counter_arbiter #(.WIDTH(WIDTH), .LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .req1_valid(req1_valid), .req1_sel(req1_sel), .req1_op(req1_op),
    .req1_data(req1_data), .req1_ready(req1_ready),
    .req2_valid(req2_valid), .req2_sel(req2_sel), .req2_op(req2_op),
    .req2_data(req2_data), .req2_ready(req2_ready),
    .counter1(counter1), .counter2(counter2), .wrap1(wrap1), .wrap2(wrap2)
  );

  typedef struct {
    logic       rst;
    logic       v1;
    logic       s1;
    logic [1:0] op1;
    logic [3:0] d1;
    logic       v2;
    logic       s2;
    logic [1:0] op2;
    logic [3:0] d2;
    logic       r1;
    logic       r2;
    logic [3:0] c1;
    logic [3:0] c2;
    logic       w1;
    logic       w2;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic v1, logic s1, logic [1:0] op1, logic [3:0] d1,
                              logic v2, logic s2, logic [1:0] op2, logic [3:0] d2,
                              logic r1, logic r2, logic [3:0] c1, logic [3:0] c2,
                              logic w1, logic w2);
    vec_t v;
    v.rst = r; v.v1 = v1; v.s1 = s1; v.op1 = op1; v.d1 = d1;
    v.v2 = v2; v.s2 = s2; v.op2 = op2; v.d2 = d2;
    v.r1 = r1; v.r2 = r2; v.c1 = c1; v.c2 = c2; v.w1 = w1; v.w2 = w2;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic r, logic v1, logic s1, logic [1:0] op1, logic [3:0] d1,
                       logic v2, logic s2, logic [1:0] op2, logic [3:0] d2);
    rst = r;
    req1_valid = v1; req1_sel = s1; req1_op = op1; req1_data = d1;
    req2_valid = v2; req2_sel = s2; req2_op = op2; req2_data = d2;
  endtask

  // Reference model state: counters, priority pointer, wrap flags.
  int m_c[2];
  int m_prio;
  int m_w[2];

  // Which requester the arbitration rules serve this cycle (0 = none).
  function automatic int model_grant(logic r, logic v1, logic v2);
    if (r) return 0;
    if (v1 && v2) return (m_prio == 0) ? 1 : 2;
    if (v1) return 1;
    if (v2) return 2;
    return 0;
  endfunction

  task automatic model_step(logic r, int g, int sel, int op, int data);
    m_w[0] = 0;
    m_w[1] = 0;
    if (r) begin
      m_c[0] = 0; m_c[1] = 0; m_prio = 0;
    end else if (g != 0) begin
      m_prio = (g == 1) ? 1 : 0;
      case (op)
        0: m_c[sel] = 0;
        1: begin
          m_w[sel] = (m_c[sel] == LIMIT - 1) ? 1 : 0;
          m_c[sel] = (m_c[sel] + 1) % LIMIT;
        end
        2: begin
          m_w[sel] = (m_c[sel] == 0) ? 1 : 0;
          m_c[sel] = (m_c[sel] + LIMIT - 1) % LIMIT;
        end
        default: m_c[sel] = (data < LIMIT) ? data : LIMIT - 1;
      endcase
    end
  endtask

  initial begin
    logic hold1, hold2;
    int   g;

    drive(1'b1, 0, 0, CLR, 0, 0, 0, CLR, 0);

    // Reset with both valids high: nothing accepted.
    vecs.push_back(mk(1, 1, 0, INC, 0, 1, 1, INC, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, INC, 0, 1, 1, INC, 0, 0, 0, 0, 0, 0, 0));
    // Requester 1 alone, 9 x INC on counter1: wraps once at the 8th.
    for (int i = 1; i <= 9; i++)
      vecs.push_back(mk(0, 1, 0, INC, 0, 0, 0, CLR, 0, 1, 0, 4'(i % LIMIT), 0, (i == 8), 0));
    vecs.push_back(mk(1, 0, 0, CLR, 0, 0, 0, CLR, 0, 0, 0, 0, 0, 0, 0));
    // Contention, different targets: strict alternation.
    vecs.push_back(mk(0, 1, 0, INC, 0, 1, 1, INC, 0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, INC, 0, 1, 1, INC, 0, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, INC, 0, 1, 1, INC, 0, 1, 0, 2, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, INC, 0, 1, 1, INC, 0, 0, 1, 2, 2, 0, 0));
    // Load saturation, load, clear, DEC wrap, then the pulse drops.
    vecs.push_back(mk(0, 0, 0, CLR, 0, 1, 0, LD, 12, 0, 1, 7, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, CLR, 0, 1, 0, LD, 3, 0, 1, 3, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, CLR, 0, 1, 0, CLR, 0, 0, 1, 0, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, CLR, 0, 1, 0, DEC, 0, 0, 1, 7, 2, 1, 0));
    vecs.push_back(mk(0, 0, 0, CLR, 0, 0, 0, CLR, 0, 0, 0, 7, 2, 0, 0));
    vecs.push_back(mk(1, 0, 0, CLR, 0, 0, 0, CLR, 0, 0, 0, 0, 0, 0, 0));
    // Shared target counter2.
    vecs.push_back(mk(0, 1, 1, INC, 0, 1, 1, INC, 0, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, INC, 0, 1, 1, INC, 0, 0, 1, 0, 2, 0, 0));
    vecs.push_back(mk(0, 1, 1, INC, 0, 1, 1, INC, 0, 1, 0, 0, 3, 0, 0));
    vecs.push_back(mk(1, 0, 0, CLR, 0, 0, 0, CLR, 0, 0, 0, 0, 0, 0, 0));
    // Contention on counter1 up to 5, reset mid-stream, req1 served first.
    for (int i = 1; i <= 5; i++)
      vecs.push_back(mk(0, 1, 0, INC, 0, 1, 0, INC, 0, (i % 2), ((i + 1) % 2), 4'(i), 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, INC, 0, 1, 0, INC, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, INC, 0, 1, 0, INC, 0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, INC, 0, 1, 0, INC, 0, 0, 1, 2, 0, 0, 0));
    // LOAD of exactly LIMIT saturates; back-to-back wraps keep wrap2 high.
    vecs.push_back(mk(0, 1, 1, LD, 8, 0, 0, CLR, 0, 1, 0, 2, 7, 0, 0));
    vecs.push_back(mk(0, 1, 1, INC, 0, 0, 0, CLR, 0, 1, 0, 2, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, CLR, 0, 1, 1, DEC, 0, 0, 1, 2, 7, 0, 1));
    vecs.push_back(mk(0, 1, 1, LD, 7, 0, 0, CLR, 0, 1, 0, 2, 7, 0, 0));

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].v1, vecs[i].s1, vecs[i].op1, vecs[i].d1,
            vecs[i].v2, vecs[i].s2, vecs[i].op2, vecs[i].d2);
      #3;
      chk($sformatf("vec%0d req1_ready", i), int'(req1_ready), int'(vecs[i].r1));
      chk($sformatf("vec%0d req2_ready", i), int'(req2_ready), int'(vecs[i].r2));
      @(posedge clk); #1;
      chk($sformatf("vec%0d counter1", i), int'(counter1), int'(vecs[i].c1));
      chk($sformatf("vec%0d counter2", i), int'(counter2), int'(vecs[i].c2));
      chk($sformatf("vec%0d wrap1", i), int'(wrap1), int'(vecs[i].w1));
      chk($sformatf("vec%0d wrap2", i), int'(wrap2), int'(vecs[i].w2));
      $display("vec %0d rst=%0d rdy=%0d%0d c1=%0d c2=%0d w=%0d%0d",
               i, vecs[i].rst, req1_ready, req2_ready, counter1, counter2, wrap1, wrap2);
    end

    // Random traffic; ungranted requesters hold their request stable.
    m_c[0] = 0; m_c[1] = 0; m_prio = 0; m_w[0] = 0; m_w[1] = 0;
    hold1 = 1'b0;
    hold2 = 1'b0;
    for (int k = 0; k < 500; k++) begin
      rst = (k == 0) || ($urandom_range(0, 59) == 0);
      if (!hold1) begin
        req1_valid = ($urandom_range(0, 3) != 0);
        req1_sel   = 1'($urandom);
        req1_op    = 2'($urandom);
        req1_data  = 4'($urandom);
      end
      if (!hold2) begin
        req2_valid = ($urandom_range(0, 3) != 0);
        req2_sel   = 1'($urandom);
        req2_op    = 2'($urandom);
        req2_data  = 4'($urandom);
      end
      g = model_grant(rst, req1_valid, req2_valid);
      #3;
      chk("rnd req1_ready", int'(req1_ready), (g == 1) ? 1 : 0);
      chk("rnd req2_ready", int'(req2_ready), (g == 2) ? 1 : 0);
      @(posedge clk); #1;
      if (g == 1) model_step(rst, g, int'(req1_sel), int'(req1_op), int'(req1_data));
      else        model_step(rst, g, int'(req2_sel), int'(req2_op), int'(req2_data));
      chk("rnd counter1", int'(counter1), m_c[0]);
      chk("rnd counter2", int'(counter2), m_c[1]);
      chk("rnd wrap1", int'(wrap1), m_w[0]);
      chk("rnd wrap2", int'(wrap2), m_w[1]);
      if (g != 0)
        $display("rnd %0d grant=req%0d c1=%0d c2=%0d w=%0d%0d",
                 k, g, counter1, counter2, wrap1, wrap2);
      hold1 = req1_valid && (g != 1);
      hold2 = req2_valid && (g != 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
